// File: rtl/t07_mem_arbiter.sv
// Two-master arbiter for the shared external memory/MMIO bus. It grants one transaction at a
// time and reports completion to each master as a single falling edge on its busy line.
module t07_mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    m0_rwi,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_busy,
  input  logic [1:0]    m1_rwi,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_busy,
  output logic [DW-1:0] rdata_o,
  output logic [1:0]    done_o,
  output logic          err_o,
  output logic [1:0]    bus_rwi_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wdata_o,
  input  logic [DW-1:0] bus_rdata_i,
  input  logic          bus_busy_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e        state_q;
  logic          owner_q;
  logic          last_grant_q;
  logic [1:0]    mask_q;
  logic [1:0]    snap0_q;
  logic [1:0]    snap1_q;
  logic          seen_busy_q;
  logic [CW-1:0] cnt_q;

  logic [1:0] pend;
  logic       winner;
  logic       st_active;
  logic       st_done;
  logic       busy_fall;
  logic       tmo;

  assign pend[0]   = (m0_rwi != 2'b00) && !mask_q[0];
  assign pend[1]   = (m1_rwi != 2'b00) && !mask_q[1];
  assign st_active = (state_q == StActive);
  assign st_done   = (state_q == StDone);
  assign busy_fall = seen_busy_q && !bus_busy_i;
  assign tmo       = !seen_busy_q && !bus_busy_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    winner = 1'b0;
    if (pend[0] && pend[1]) begin
      winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      winner = ~pend[0];
    end
  end

  // The owner drops busy in DONE; the mask keeps it low while the request is still held.
  assign m0_busy = (pend[0] | (st_active & ~owner_q)) & ~(st_done & ~owner_q);
  assign m1_busy = (pend[1] | (st_active & owner_q)) & ~(st_done & owner_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mask_q       <= 2'b00;
      snap0_q      <= 2'b00;
      snap1_q      <= 2'b00;
      seen_busy_q  <= 1'b0;
      cnt_q        <= '0;
      rdata_o      <= '0;
      done_o       <= 2'b00;
      err_o        <= 1'b0;
      bus_rwi_o    <= 2'b00;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
    end else begin
      done_o <= 2'b00;
      err_o  <= 1'b0;
      if (m0_rwi == 2'b00 || m0_rwi != snap0_q) mask_q[0] <= 1'b0;
      if (m1_rwi == 2'b00 || m1_rwi != snap1_q) mask_q[1] <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (|pend) begin
            owner_q      <= winner;
            last_grant_q <= winner;
            bus_rwi_o    <= winner ? m1_rwi : m0_rwi;
            bus_addr_o   <= winner ? m1_addr : m0_addr;
            bus_wdata_o  <= winner ? m1_wdata : m0_wdata;
            state_q      <= StActive;
          end
        end
        StActive: begin
          if (bus_busy_i) seen_busy_q <= 1'b1;
          if (!seen_busy_q) cnt_q <= cnt_q + CW'(1);
          if (busy_fall || tmo) begin
            rdata_o     <= busy_fall ? bus_rdata_i : '0;
            err_o       <= tmo;
            done_o      <= owner_q ? 2'b10 : 2'b01;
            bus_rwi_o   <= 2'b00;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // Setting the mask here overrides the re-arm update above for the owner.
          mask_q[owner_q] <= 1'b1;
          if (owner_q) snap1_q <= m1_rwi;
          else         snap0_q <= m0_rwi;
          seen_busy_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_t07_mem_arbiter.sv
// Scoreboard bench for t07_mem_arbiter: a round-robin and a fixed-priority instance share the
// master stimulus, each with its own small bus responder and expected-completion queue.
module tb_t07_mem_arbiter;

  typedef struct {
    logic        owner;
    logic [1:0]  rwi;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m0_rwi = 2'b00, m1_rwi = 2'b00;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

  logic        m0_busy, m1_busy, err_o;
  logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
  logic [1:0]  done_o, bus_rwi_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_busy_i = 1'b0;

  logic        f_m0_busy, f_m1_busy, f_err_o;
  logic [31:0] f_rdata_o, f_bus_addr_o, f_bus_wdata_o;
  logic [1:0]  f_done_o, f_bus_rwi_o;
  logic [31:0] f_bus_rdata_i = '0;
  logic        f_bus_busy_i = 1'b0;

  int   lat = 3;
  bit   bus_mute = 1'b0;
  int   bcnt0 = 0, bcnt1 = 0;
  int   total = 0, bad = 0;
  int   fall_cnt[2] = '{0, 0};
  int   exp_fall[2] = '{0, 0};
  logic prev_busy[2] = '{1'b0, 1'b0};
  logic [1:0] prev_done[2] = '{2'b00, 2'b00};
  exp_t exp_q[$];
  exp_t fix_q[$];

  t07_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .m0_rwi(m0_rwi), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_busy(m0_busy),
    .m1_rwi(m1_rwi), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_busy(m1_busy),
    .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o),
    .bus_rwi_o(bus_rwi_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_busy_i(bus_busy_i)
  );

  t07_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .m0_rwi(m0_rwi), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_busy(f_m0_busy),
    .m1_rwi(m1_rwi), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_busy(f_m1_busy),
    .rdata_o(f_rdata_o), .done_o(f_done_o), .err_o(f_err_o),
    .bus_rwi_o(f_bus_rwi_o), .bus_addr_o(f_bus_addr_o), .bus_wdata_o(f_bus_wdata_o),
    .bus_rdata_i(f_bus_rdata_i), .bus_busy_i(f_bus_busy_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hCAFE_F00D : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic exp_t mk(input logic o, input logic [1:0] r, input logic [31:0] a,
                              input logic [31:0] w, input logic [31:0] d, input logic e);
    exp_t x;
    x.owner = o; x.rwi = r; x.addr = a; x.wdata = w; x.rdata = d; x.err = e;
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_main(input exp_t e);
    exp_q.push_back(e);
    exp_fall[e.owner]++;
  endtask

  // Bus responders: busy for `lat` cycles once a request appears, then return data.
  always @(negedge clk) begin
    if (bus_rwi_o != 2'b00 && !bus_mute) begin
      if (bcnt0 < lat) begin bus_busy_i = 1'b1; bus_rdata_i = 32'h0BAD_0BAD; bcnt0++; end
      else begin bus_busy_i = 1'b0; bus_rdata_i = rd_of(bus_addr_o); end
    end else begin
      bus_busy_i = 1'b0; bcnt0 = 0;
    end
  end

  always @(negedge clk) begin
    if (f_bus_rwi_o != 2'b00 && !bus_mute) begin
      if (bcnt1 < lat) begin f_bus_busy_i = 1'b1; f_bus_rdata_i = 32'h0BAD_0BAD; bcnt1++; end
      else begin f_bus_busy_i = 1'b0; f_bus_rdata_i = rd_of(f_bus_addr_o); end
    end else begin
      f_bus_busy_i = 1'b0; bcnt1 = 0;
    end
  end

  task automatic mon(input int w, input logic [1:0] rwi, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic [1:0] done,
                     input logic err);
    exp_t e;
    logic have;
    have = 1'b0;
    if (w == 0) begin
      have = (exp_q.size() > 0);
      if (have) e = exp_q[0];
    end else begin
      have = (fix_q.size() > 0);
      if (have) e = fix_q[0];
    end
    if (rwi != 2'b00) begin
      check($sformatf("grant_expected[%0d]", w), {63'd0, have}, 64'd1);
      if (have) begin
        check($sformatf("bus_rwi[%0d]", w), {62'd0, rwi}, {62'd0, e.rwi});
        check($sformatf("bus_addr[%0d]", w), {32'd0, addr}, {32'd0, e.addr});
        check($sformatf("bus_wdata[%0d]", w), {32'd0, wdata}, {32'd0, e.wdata});
      end
    end
    if (done != 2'b00 || err) begin
      check($sformatf("done_expected[%0d]", w), {63'd0, have}, 64'd1);
      check($sformatf("done_pulse[%0d]", w), {62'd0, prev_done[w]}, 64'd0);
      if (have) begin
        check($sformatf("done_owner[%0d]", w), {62'd0, done}, e.owner ? 64'd2 : 64'd1);
        check($sformatf("err[%0d]", w), {63'd0, err}, {63'd0, e.err});
        check($sformatf("rdata[%0d]", w), {32'd0, rdata}, {32'd0, e.rdata});
        if (w == 0) void'(exp_q.pop_front());
        else        void'(fix_q.pop_front());
      end
    end
    prev_done[w] = done;
  endtask

  always @(negedge clk) begin
    mon(0, bus_rwi_o, bus_addr_o, bus_wdata_o, rdata_o, done_o, err_o);
    mon(1, f_bus_rwi_o, f_bus_addr_o, f_bus_wdata_o, f_rdata_o, f_done_o, f_err_o);
    if (prev_busy[0] && !m0_busy) fall_cnt[0]++;
    if (prev_busy[1] && !m1_busy) fall_cnt[1]++;
    prev_busy[0] = m0_busy;
    prev_busy[1] = m1_busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    check("rst_bus_rwi", {62'd0, bus_rwi_o}, 64'd0);
    check("rst_done", {62'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_rdata", {32'd0, rdata_o}, 64'd0);

    // Single M0 read.
    push_main(mk(1'b0, 2'b10, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h100, 32'h0, 32'hCAFE_F00D, 1'b0));
    m0_addr = 32'h100; m0_rwi = 2'b10;
    cyc(1);
    check("lat_bus_addr", {32'd0, bus_addr_o}, 64'h100);
    check("lat_bus_rwi", {62'd0, bus_rwi_o}, 64'd2);
    check("m0_busy_active", {63'd0, m0_busy}, 64'd1);
    cyc(24);
    check("rdata_hold", {32'd0, rdata_o}, 64'hCAFE_F00D);
    m0_rwi = 2'b00;
    cyc(2);

    // Simultaneous requests; last grant was M0, so round-robin serves M1 first.
    lat = 2;
    m0_addr = 32'h104; m1_addr = 32'h204; m1_wdata = 32'h1111_0000;
    push_main(mk(1'b1, 2'b10, 32'h204, 32'h1111_0000, rd_of(32'h204), 1'b0));
    push_main(mk(1'b0, 2'b10, 32'h104, 32'h0, rd_of(32'h104), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h104, 32'h0, rd_of(32'h104), 1'b0));
    fix_q.push_back(mk(1'b1, 2'b10, 32'h204, 32'h1111_0000, rd_of(32'h204), 1'b0));
    m0_rwi = 2'b10; m1_rwi = 2'b10;
    cyc(1);
    check("rr_loser_busy", {63'd0, m0_busy}, 64'd1);
    check("fix_loser_busy", {63'd0, f_m1_busy}, 64'd1);
    cyc(24);
    m0_rwi = 2'b00; m1_rwi = 2'b00;
    cyc(1);

    // Both repeat; last grant was M0 again for round-robin.
    m0_addr = 32'h108; m1_addr = 32'h208;
    push_main(mk(1'b1, 2'b10, 32'h208, 32'h1111_0000, rd_of(32'h208), 1'b0));
    push_main(mk(1'b0, 2'b11, 32'h108, 32'h0, rd_of(32'h108), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b11, 32'h108, 32'h0, rd_of(32'h108), 1'b0));
    fix_q.push_back(mk(1'b1, 2'b10, 32'h208, 32'h1111_0000, rd_of(32'h208), 1'b0));
    m0_rwi = 2'b11; m1_rwi = 2'b10;
    cyc(25);
    m0_rwi = 2'b00; m1_rwi = 2'b00;
    cyc(1);

    // Held request is not re-granted; 11->10 re-arms directly; 00 then 11 re-arms.
    lat = 1;
    m0_addr = 32'h10C;
    push_main(mk(1'b0, 2'b11, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b11, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    m0_rwi = 2'b11;
    cyc(25);
    check("held_masked_busy", {63'd0, m0_busy}, 64'd0);
    push_main(mk(1'b0, 2'b10, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    m0_rwi = 2'b10;
    cyc(25);
    m0_rwi = 2'b00;
    cyc(1);
    push_main(mk(1'b0, 2'b11, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b11, 32'h10C, 32'h0, rd_of(32'h10C), 1'b0));
    m0_rwi = 2'b11;
    cyc(25);
    m0_rwi = 2'b00;
    cyc(1);

    // Timeout: four ACTIVE cycles with no busy, then DONE with err.
    bus_mute = 1'b1;
    m0_addr = 32'h110;
    push_main(mk(1'b0, 2'b10, 32'h110, 32'h0, 32'h0, 1'b1));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h110, 32'h0, 32'h0, 1'b1));
    m0_rwi = 2'b10;
    cyc(5);
    check("tmo_done_cycle", {62'd0, done_o}, 64'd1);
    check("tmo_err_cycle", {63'd0, err_o}, 64'd1);
    cyc(20);
    bus_mute = 1'b0; m0_rwi = 2'b00;
    cyc(1);

    // M1 write; its inputs change mid-transaction but the bus must not follow.
    lat = 4;
    m1_addr = 32'h200; m1_wdata = 32'hDEAD_0001;
    push_main(mk(1'b1, 2'b01, 32'h200, 32'hDEAD_0001, rd_of(32'h200), 1'b0));
    fix_q.push_back(mk(1'b1, 2'b01, 32'h200, 32'hDEAD_0001, rd_of(32'h200), 1'b0));
    m1_rwi = 2'b01;
    cyc(3);
    m1_addr = 32'h2FC; m1_wdata = 32'h1234_5678;
    cyc(1);
    check("wr_addr_stable", {32'd0, bus_addr_o}, 64'h200);
    check("wr_wdata_stable", {32'd0, bus_wdata_o}, 64'hDEAD_0001);
    cyc(22);
    m1_rwi = 2'b00;
    cyc(1);
    check("m0_falls", fall_cnt[0], exp_fall[0]);
    check("m1_falls", fall_cnt[1], exp_fall[1]);

    // Reset mid-ACTIVE aborts silently; fresh simultaneous request goes to M0.
    lat = 5;
    m0_addr = 32'h300;
    exp_q.push_back(mk(1'b0, 2'b10, 32'h300, 32'h0, rd_of(32'h300), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h300, 32'h0, rd_of(32'h300), 1'b0));
    m0_rwi = 2'b10;
    cyc(3);
    rst = 1'b1; m0_rwi = 2'b00;
    cyc(1);
    rst = 1'b0;
    void'(exp_q.pop_front());
    void'(fix_q.pop_front());
    check("abort_bus_rwi", {62'd0, bus_rwi_o}, 64'd0);
    check("abort_bus_addr", {32'd0, bus_addr_o}, 64'd0);
    check("abort_done", {62'd0, done_o}, 64'd0);
    check("abort_err", {63'd0, err_o}, 64'd0);
    check("abort_rdata", {32'd0, rdata_o}, 64'd0);
    check("abort_fix_rwi", {62'd0, f_bus_rwi_o}, 64'd0);
    lat = 2;
    m0_addr = 32'h400; m1_addr = 32'h500; m1_wdata = 32'h0;
    exp_q.push_back(mk(1'b0, 2'b10, 32'h400, 32'h0, rd_of(32'h400), 1'b0));
    exp_q.push_back(mk(1'b1, 2'b10, 32'h500, 32'h0, rd_of(32'h500), 1'b0));
    fix_q.push_back(mk(1'b0, 2'b10, 32'h400, 32'h0, rd_of(32'h400), 1'b0));
    fix_q.push_back(mk(1'b1, 2'b10, 32'h500, 32'h0, rd_of(32'h500), 1'b0));
    m0_rwi = 2'b10; m1_rwi = 2'b10;
    cyc(25);
    m0_rwi = 2'b00; m1_rwi = 2'b00;
    cyc(2);

    check("main_queue_empty", exp_q.size(), 64'd0);
    check("fix_queue_empty", fix_q.size(), 64'd0);
    check("busy_idle", {60'd0, m0_busy, m1_busy, f_m0_busy, f_m1_busy}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
